// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter and its grant selector.
package dmem_arb_pkg;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_e;

    localparam int STREAK_WIDTH = 4;

    typedef logic [STREAK_WIDTH-1:0] streak_t;

endpackage

// File: rtl/arb_select.sv
// Pure two-requester grant logic: fixed priority with a streak limit, or round-robin.
// Returns a one-hot grant, bit 0 = cpu, bit 1 = dbg.
module arb_select
    import dmem_arb_pkg::*;
#(
    parameter int CPU_PRIORITY   = 1,
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic       cpu_req,
    input  logic       dbg_req,
    input  req_id_e    last_gnt,
    input  streak_t    streak,
    output logic [1:0] gnt
);

    localparam streak_t STREAK_MAX = streak_t'(MAX_CPU_STREAK);

    generate
        if (CPU_PRIORITY != 0) begin : g_prio
            logic dbg_win;
            logic unused_last;

            // dbg only overrides cpu once the processor has used up its streak
            assign dbg_win     = dbg_req && (!cpu_req || (streak == STREAK_MAX));
            assign gnt[1]      = dbg_win;
            assign gnt[0]      = cpu_req && !dbg_win;
            assign unused_last = last_gnt;
        end else begin : g_rr
            logic both;
            logic unused_streak;

            assign both          = cpu_req && dbg_req;
            assign gnt[0]        = cpu_req && (!both || (last_gnt == REQ_DBG));
            assign gnt[1]        = dbg_req && !gnt[0];
            assign unused_streak = ^streak;
        end
    endgenerate

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port dmem between the processor and the debug/loader port.
// Grants are combinational; read data returns one cycle after a read grant.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CPU_PRIORITY   = 1,
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_wstrb,
    output logic                    cpu_gnt,
    output logic                    cpu_rvalid,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,

    input  logic                    dbg_req,
    input  logic                    dbg_we,
    input  logic [ADDR_WIDTH-1:0]   dbg_addr,
    input  logic [DATA_WIDTH-1:0]   dbg_wdata,
    input  logic [DATA_WIDTH/8-1:0] dbg_wstrb,
    output logic                    dbg_gnt,
    output logic                    dbg_rvalid,
    output logic [DATA_WIDTH-1:0]   dbg_rdata,

    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-3:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int      STRB_WIDTH = DATA_WIDTH / 8;
    localparam streak_t STREAK_MAX = streak_t'(MAX_CPU_STREAK);

    logic [1:0] sel;
    streak_t    streak_reg, streak_next;
    req_id_e    last_gnt_reg, last_gnt_next;
    logic       rvalid_reg, rvalid_next;
    req_id_e    rd_owner_reg, rd_owner_next;
    logic       unused_addr_lsbs;

    arb_select #(
        .CPU_PRIORITY  (CPU_PRIORITY),
        .MAX_CPU_STREAK(MAX_CPU_STREAK)
    ) u_arb_select (
        .cpu_req (cpu_req),
        .dbg_req (dbg_req),
        .last_gnt(last_gnt_reg),
        .streak  (streak_reg),
        .gnt     (sel)
    );

    // Grants are forced low while reset is held so dmem sees no stray access.
    assign cpu_gnt = sel[0] & reset;
    assign dbg_gnt = sel[1] & reset;
    assign mem_en  = cpu_gnt | dbg_gnt;

    assign unused_addr_lsbs = ^{cpu_addr[1:0], dbg_addr[1:0]};

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr[ADDR_WIDTH-1:2];
            mem_wdata = dbg_wdata;
            mem_wstrb = dbg_wstrb;
        end else if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr[ADDR_WIDTH-1:2];
            mem_wdata = cpu_wdata;
            mem_wstrb = cpu_wstrb;
        end
    end

    always_comb begin
        streak_next   = streak_reg;
        last_gnt_next = last_gnt_reg;
        rvalid_next   = 1'b0;
        rd_owner_next = rd_owner_reg;

        if (dbg_gnt || !dbg_req) begin
            streak_next = '0;
        end else if (cpu_gnt && (streak_reg != STREAK_MAX)) begin
            streak_next = streak_reg + streak_t'(1);
        end

        if (dbg_gnt) begin
            last_gnt_next = REQ_DBG;
            rvalid_next   = !dbg_we;
            rd_owner_next = REQ_DBG;
        end else if (cpu_gnt) begin
            last_gnt_next = REQ_CPU;
            rvalid_next   = !cpu_we;
            rd_owner_next = REQ_CPU;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_reg   <= '0;
            last_gnt_reg <= REQ_DBG;
            rvalid_reg   <= 1'b0;
            rd_owner_reg <= REQ_CPU;
        end else begin
            streak_reg   <= streak_next;
            last_gnt_reg <= last_gnt_next;
            rvalid_reg   <= rvalid_next;
            rd_owner_reg <= rd_owner_next;
        end
    end

    assign cpu_rvalid = rvalid_reg && (rd_owner_reg == REQ_CPU);
    assign dbg_rvalid = rvalid_reg && (rd_owner_reg == REQ_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

    // Strobe width must cover the data bus exactly.
    generate
        if (STRB_WIDTH * 8 != DATA_WIDTH) begin : g_bad_width
            logic unused_bad_width;
            assign unused_bad_width = 1'b0;
        end
    endgenerate

endmodule
